// File: rtl/rope_frame_scheduler.sv
// Per-frame rope sequencer: latch pointer, issue STEPS physics steps, copy NODES nodes, swap buffers.
// Optional step watchdog is enabled by defining ROPE_WATCHDOG_EN.
module rope_frame_scheduler #(
  parameter int NODES   = 20,
  parameter int STEPS   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  output logic       step_req,
  input  logic       step_ack,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic       copy_we,
  output logic [4:0] copy_idx,
  output logic       buf_sel,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       timeout_err
);

  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);
  localparam logic [4:0] LAST_IDX  = 5'(NODES - 1);

  if (STEPS < 1 || STEPS > 15 || NODES < 1 || NODES > 32 || TIMEOUT < 1) begin : g_bad_cfg
    $error("rope_frame_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_COPY = 3'd3,
    S_SWAP = 3'd4
  } state_t;

  state_t     state_q;
  logic [3:0] step_cnt_q;
  logic [9:0] target_x_q;
  logic [9:0] target_y_q;
  logic       step_req_q;
  logic       copy_we_q;
  logic [4:0] copy_idx_q;
  logic       buf_sel_q;
  logic       busy_q;
  logic       done_q;
  logic       overrun_q;

`ifdef ROPE_WATCHDOG_EN
  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
`endif

  // Frame FSM; every output is a register updated together with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      step_cnt_q <= 4'd0;
      target_x_q <= 10'd0;
      target_y_q <= 10'd0;
      step_req_q <= 1'b0;
      copy_we_q  <= 1'b0;
      copy_idx_q <= 5'd0;
      buf_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef ROPE_WATCHDOG_EN
      wd_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // busy_q mirrors "state is not IDLE", so ticks in SWAP also count as overrun.
      if (frame_tick && busy_q) begin
        overrun_q <= 1'b1;
      end else begin
        overrun_q <= overrun_q;
      end
      case (state_q)
        S_IDLE: begin
          if (frame_tick) begin
            target_x_q <= mouse_x;
            target_y_q <= mouse_y;
            step_cnt_q <= 4'd0;
            step_req_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_REQ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_REQ: begin
          if (step_ack) begin
            step_req_q <= 1'b0;
            step_cnt_q <= step_cnt_q + 4'd1;
`ifdef ROPE_WATCHDOG_EN
            wd_q       <= '0;
`endif
            if (step_cnt_q == LAST_STEP) begin
              copy_we_q  <= 1'b1;
              copy_idx_q <= 5'd0;
              state_q    <= S_COPY;
            end else begin
              state_q <= S_GAP;
            end
          end
`ifdef ROPE_WATCHDOG_EN
          else if (wd_q == WD_LAST) begin
            step_req_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b1;
            wd_q       <= '0;
            state_q    <= S_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`else
          else begin
            state_q <= S_REQ;
          end
`endif
        end
        S_GAP: begin
          step_req_q <= 1'b1;
          state_q    <= S_REQ;
        end
        S_COPY: begin
          if (copy_idx_q == LAST_IDX) begin
            copy_we_q  <= 1'b0;
            copy_idx_q <= 5'd0;
            done_q     <= 1'b1;
            state_q    <= S_SWAP;
          end else begin
            copy_idx_q <= copy_idx_q + 5'd1;
          end
        end
        S_SWAP: begin
          buf_sel_q <= ~buf_sel_q;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          step_req_q <= 1'b0;
          copy_we_q  <= 1'b0;
          copy_idx_q <= 5'd0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign step_req = step_req_q;
  assign target_x = target_x_q;
  assign target_y = target_y_q;
  assign copy_we  = copy_we_q;
  assign copy_idx = copy_idx_q;
  assign buf_sel  = buf_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
`ifdef ROPE_WATCHDOG_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/rope_frame_scheduler.md
ROPE_FRAME_SCHEDULER -- requirements
Module: rope_frame_scheduler

Interface
REQ-001 Parameter NODES, 20, number of rope nodes copied per frame.
REQ-002 Parameter STEPS, 4, rope physics steps issued per frame (1..15).
REQ-003 Parameter TIMEOUT, 1024, watchdog limit in clk cycles per step request.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low; 0 = reset.
REQ-006 frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 mouse_x, mouse_y  input  10 each  current pointer position.
REQ-008 step_req  output  1  request one rope physics step.
REQ-009 step_ack  input  1  rope engine has completed the requested step.
REQ-010 target_x, target_y  output  10 each  per-frame latched pointer position driven to the rope engine.
REQ-011 copy_we  output  1  write strobe into the back node buffer.
REQ-012 copy_idx  output  5  node index being copied.
REQ-013 buf_sel  output  1  front-buffer select for the renderer.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 done  output  1  one-cycle pulse in the SWAP state.
REQ-016 overrun  output  1  sticky flag: frame_tick arrived while busy.
REQ-017 timeout_err  output  1  sticky watchdog flag.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, GAP, COPY and SWAP.
REQ-019 IDLE: frame_tick=1 SHALL latch mouse_x/y into target_x/y, clear the step count and enter REQ on the next cycle.
REQ-020 REQ: step_req SHALL be 1; step_ack=1 SHALL increment the step count; if the count reaches STEPS, go to COPY, otherwise go to GAP.
REQ-021 GAP: step_req SHALL be 0 for exactly one cycle, then return to REQ.
REQ-022 step_req SHALL be 0 in every state except REQ; step_ack outside REQ SHALL be ignored.
REQ-023 COPY: copy_we SHALL be 1 for exactly NODES consecutive cycles with copy_idx = 0..NODES-1 in order, then enter SWAP.
REQ-024 SWAP: done SHALL be 1 for one cycle; buf_sel SHALL toggle, with the new value visible from the next cycle; then enter IDLE.
REQ-025 target_x/y SHALL remain stable from latch until the next accepted frame_tick.
REQ-026 A frame_tick while busy=1, including in SWAP, SHALL be ignored and SHALL set overrun.
REQ-027 With an immediate ack, latency SHALL be frame_tick at cycle 0 to done at cycle 2*STEPS+NODES.
REQ-028 copy_idx SHALL be 0 whenever copy_we=0.

Reset
REQ-029 When reset=0 at a clk edge, the block SHALL enter IDLE; step_req, copy_we, copy_idx, done, busy, overrun, timeout_err and buf_sel SHALL be 0, and target_x/y SHALL be 0.
REQ-030 Reset mid-frame SHALL abort immediately without a buf_sel toggle; a pending step_ack after reset SHALL be ignored.
REQ-031 overrun and timeout_err SHALL clear only on reset.

Configuration
REQ-032 Macro ROPE_WATCHDOG_EN defined: a counter SHALL run while in REQ and SHALL clear on ack or on leaving REQ. If it reaches TIMEOUT, the block SHALL drop step_req, set timeout_err and return to IDLE without COPY or SWAP.
REQ-033 Macro ROPE_WATCHDOG_EN undefined: REQ SHALL wait indefinitely, and timeout_err SHALL be constant 0.

Verification
REQ-034 Defaults, step_ack tied 1, frame_tick at cycle 0 -> step_req high in cycles 1,3,5,7; copy_we in cycles 8..27 with idx 0..19; done in cycle 28; buf_sel=1 from cycle 29.
REQ-035 mouse_x=300, mouse_y=200 at tick, then changed to 10/10 mid-frame -> target_x/y hold 300/200 through done.
REQ-036 Second frame_tick at cycle 12 -> ignored, overrun=1, timing identical to REQ-034.
REQ-037 reset=0 at cycle 15 -> all outputs zero at cycle 16; buf_sel stays 0; the next frame_tick starts a clean frame.
REQ-038 ROPE_WATCHDOG_EN, TIMEOUT=16, step_ack tied 0 -> step_req drops after 16 cycles; timeout_err=1; no copy_we; buf_sel unchanged.
REQ-039 Ack delayed 5 cycles per step -> step_req held until ack; exactly 4 acks counted; copy and swap then proceed normally.
